bcd_to_bin_seq: RTL and testbench

//  Sequential BCD-to-binary converter. It takes a packed NUM_DIGITS-digit BCD

---
 rtl/bcd_to_bin_seq_pkg.sv | 14 +
 rtl/bcd_mac_step.sv | 18 +
 rtl/bcd_to_bin_seq.sv | 99 +++++++++
 tb/tb_bcd_to_bin_seq.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter: FSM state
// encoding, BCD digit width and the largest legal decimal digit.
package bcd_to_bin_seq_pkg;

  localparam int         DIGIT_W       = 4;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_mac_step.sv
// One decimal multiply-accumulate step: acc_o = acc_i*10 + digit_i, built from
// shifts and adds so no multiplier is inferred.
module bcd_mac_step #(
  parameter int BIN_WIDTH = 10
) (
  input  logic [BIN_WIDTH-1:0] acc_i,
  input  logic [3:0]           digit_i,
  output logic [BIN_WIDTH-1:0] acc_o
);

  logic [BIN_WIDTH-1:0] acc_x8;
  logic [BIN_WIDTH-1:0] acc_x2;

  assign acc_x8 = acc_i << 3;
  assign acc_x2 = acc_i << 1;
  assign acc_o  = acc_x8 + acc_x2 + BIN_WIDTH'(digit_i);

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter with start/busy/done handshake.
// Digits are consumed MSD-first, one multiply-accumulate per clock.
module bcd_to_bin_seq
  import bcd_to_bin_seq_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter int BIN_WIDTH  = 10
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [4*NUM_DIGITS-1:0] i_bcd,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [BIN_WIDTH-1:0]    o_bin,
  output logic                    o_err
);

  localparam int BCD_W = DIGIT_W * NUM_DIGITS;
  localparam int CNT_W = $clog2(NUM_DIGITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_DIGITS - 1);

  state_e               state_q;
  logic [BCD_W-1:0]     sreg_q;
  logic [BIN_WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [BIN_WIDTH-1:0] bin_q;
  logic                 err_q;
  logic                 done_q;

  logic [BIN_WIDTH-1:0]  acc_d;
  logic [NUM_DIGITS-1:0] nib_bad;
  logic                  any_bad;

  // Per-nibble range check on the raw input, evaluated only at the start edge.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit_chk
    assign nib_bad[g] = (i_bcd[DIGIT_W*g +: DIGIT_W] > BCD_MAX_DIGIT);
  end
  assign any_bad = |nib_bad;

  bcd_mac_step #(
    .BIN_WIDTH(BIN_WIDTH)
  ) u_mac (
    .acc_i  (acc_q),
    .digit_i(sreg_q[BCD_W-1 -: DIGIT_W]),
    .acc_o  (acc_d)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            sreg_q <= i_bcd;
            acc_q  <= '0;
            cnt_q  <= '0;
            if (any_bad) begin
              bin_q   <= '0;
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_CONV;
            end
          end
        end
        ST_CONV: begin
          acc_q  <= acc_d;
          sreg_q <= sreg_q << DIGIT_W;
          cnt_q  <= cnt_q + 1'b1;
          // Last digit: publish the freshly accumulated value, not acc_q.
          if (cnt_q == CNT_LAST) begin
            bin_q   <= acc_d;
            err_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_busy = (state_q != ST_IDLE);
  assign o_done = done_q;
  assign o_bin  = bin_q;
  assign o_err  = err_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Randomised and exhaustive bench for bcd_to_bin_seq with a queue scoreboard
// fed at each start and drained by an independent o_done monitor.
module tb_bcd_to_bin_seq;

  localparam int ND = 3;
  localparam int BW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [4*ND-1:0] bcd;
  logic          busy;
  logic          done;
  logic [BW-1:0] bin;
  logic          err;

  always #5 clk = ~clk;

  bcd_to_bin_seq #(
    .NUM_DIGITS(ND),
    .BIN_WIDTH (BW)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_start(start),
    .i_bcd  (bcd),
    .o_busy (busy),
    .o_done (done),
    .o_bin  (bin),
    .o_err  (err)
  );

  typedef struct {
    int bin;
    int err;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   total   = 0;
  int   bad     = 0;
  int   cyc     = 0;
  int   ndone   = 0;
  int   npushed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Decimal meaning of a packed BCD word; any nibble above 9 is an error.
  function automatic void ref_conv(input logic [4*ND-1:0] v, output int n, output int e);
    int w;
    n = 0;
    e = 0;
    w = 1;
    for (int i = 0; i < ND; i++) begin
      int d;
      d = int'((v >> (4 * i)) & 'hF);
      if (d > 9) e = 1;
      n = n + d * w;
      w = w * 10;
    end
    if (e != 0) n = 0;
  endfunction

  function automatic logic [4*ND-1:0] bin_to_bcd(input int n);
    logic [4*ND-1:0] r;
    int m;
    r = '0;
    m = n;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (done === 1'b1) begin
      exp_t e;
      ndone++;
      chk("done_expected", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("bin", int'(bin), e.bin);
        chk("err", int'(err), e.err);
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 20 && busy; i++) begin
      @(posedge clk);
      #1;
    end
    if (busy) chk("idle_timeout", int'(busy), 0);
  endtask

  // Issue one start; when push is set the expected result goes on the scoreboard.
  task automatic issue(input logic [4*ND-1:0] v, input bit push,
                       input bit use_n, input int n_req);
    int n, e, edge_c;
    wait_idle();
    bcd   = v;
    start = 1'b1;
    @(posedge clk);
    #1;
    edge_c = cyc;
    start  = 1'b0;
    bcd    = 12'($urandom);
    if (push) begin
      ref_conv(v, n, e);
      if (use_n) n = n_req;
      sb.push_back('{bin: n, err: e, cyc: edge_c + ((e != 0) ? 0 : ND)});
      npushed++;
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    bcd   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bin", int'(bin), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    issue(12'h255, 1'b1, 1'b1, 255);
    for (int i = 0; i < 4; i++) begin
      chk("busy_during_conv", int'(busy), 1);
      @(posedge clk);
      #1;
    end
    chk("busy_after_done", int'(busy), 0);

    issue(12'h999, 1'b1, 1'b1, 999);
    issue(12'h000, 1'b1, 1'b1, 0);
    issue(12'h1A3, 1'b1, 1'b0, 0);
    issue(12'h042, 1'b1, 1'b1, 42);

    // Start pulses inside CONV and DONE must not spawn extra results.
    issue(12'h123, 1'b1, 1'b1, 123);
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;

    // Reset in the second CONV cycle discards the conversion.
    issue(12'h777, 1'b0, 1'b0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_bin", int'(bin), 0);
    chk("midrst_err", int'(err), 0);
    chk("midrst_done", int'(done), 0);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    for (int i = 0; i < 300; i++) issue(12'($urandom), 1'b1, 1'b0, 0);
    for (int n = 0; n < 1000; n++) issue(bin_to_bcd(n), 1'b1, 1'b1, n);

    wait_idle();
    repeat (10) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    chk("done_count", ndone, npushed);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
